// File: rtl/comparch_pkg.sv
// Shared widths, sizes and source-slot indices for the dual-issue register file.
package comparch_pkg;
   localparam int REG_AW   = 3;
   localparam int DATA_W   = 32;
   localparam int NUM_REGS = 8;
   localparam int NUM_SRC  = 5;

   localparam int SRC_I1_RD = 0;
   localparam int SRC_I1_RM = 1;
   localparam int SRC_I2_RD = 2;
   localparam int SRC_I2_RM = 3;
   localparam int SRC_I2_RN = 4;

   typedef struct packed {
      logic              en;
      logic [REG_AW-1:0] addr;
      logic [DATA_W-1:0] data;
   } wb_t;

   function automatic logic addr_hit(input logic en, input logic [REG_AW-1:0] a,
                                     input logic [REG_AW-1:0] b);
      return en && (a == b);
   endfunction
endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: per-register in-flight flags, source hazard detection and
// intra-pair dependency check for the two decode slots.
module rf_scoreboard
   import comparch_pkg::*;
#(
   parameter int NUM_REGS = comparch_pkg::NUM_REGS
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_SRC-1:0][REG_AW-1:0]   src_addr,
   input  logic [NUM_SRC-1:0]               src_en,
   input  logic                             wb1_en,
   input  logic [REG_AW-1:0]                wb1_addr,
   input  logic                             wb2_en,
   input  logic [REG_AW-1:0]                wb2_addr,
   input  logic                             iss1_en,
   input  logic [REG_AW-1:0]                iss1_dst,
   input  logic                             iss2_en,
   input  logic [REG_AW-1:0]                iss2_dst,
   output logic                             stall,
   output logic                             pair_dep
);
   logic [NUM_REGS-1:0] busy, busy_nxt;
   logic [NUM_SRC-1:0]  hazard;

   // A writeback landing this cycle resolves the hazard via the bypass path.
   always_comb begin
      hazard   = '0;
      pair_dep = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         hazard[i] = src_en[i] && busy[src_addr[i]]
                     && !addr_hit(wb1_en, wb1_addr, src_addr[i])
                     && !addr_hit(wb2_en, wb2_addr, src_addr[i]);
      end
      for (int i = SRC_I2_RD; i <= SRC_I2_RN; i++) begin
         if (iss1_en && src_en[i] && (src_addr[i] == iss1_dst))
            pair_dep = 1'b1;
      end
   end

   assign stall = |hazard;

   // Clears applied first so a same-cycle claim on the same register wins.
   always_comb begin
      busy_nxt = busy;
      if (wb1_en) busy_nxt[wb1_addr] = 1'b0;
      if (wb2_en) busy_nxt[wb2_addr] = 1'b0;
      if (!stall && iss1_en)              busy_nxt[iss1_dst] = 1'b1;
      if (!stall && !pair_dep && iss2_en) busy_nxt[iss2_dst] = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) busy <= '0;
      else       busy <= busy_nxt;
   end
endmodule

// File: rtl/reg_file_scoreboard.sv
// Dual-issue register file: five combinational read ports with writeback bypass,
// two write ports (wb2 younger), and the busy-bit scoreboard.
module reg_file_scoreboard
   import comparch_pkg::*;
#(
   parameter int NUM_REGS = comparch_pkg::NUM_REGS
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] i1_Rd,
   input  logic [REG_AW-1:0] i1_Rm,
   input  logic [REG_AW-1:0] i2_Rd,
   input  logic [REG_AW-1:0] i2_Rm,
   input  logic [REG_AW-1:0] i2_Rn,
   input  logic [NUM_SRC-1:0] src_en,
   output logic [DATA_W-1:0] i1_regRd,
   output logic [DATA_W-1:0] i1_regRm,
   output logic [DATA_W-1:0] i2_regRd,
   output logic [DATA_W-1:0] i2_regRm,
   output logic [DATA_W-1:0] i2_regRn,
   input  logic              wb1_en,
   input  logic              wb2_en,
   input  logic [REG_AW-1:0] wb1_addr,
   input  logic [REG_AW-1:0] wb2_addr,
   input  logic [DATA_W-1:0] wb1_data,
   input  logic [DATA_W-1:0] wb2_data,
   input  logic              iss1_en,
   input  logic              iss2_en,
   input  logic [REG_AW-1:0] iss1_dst,
   input  logic [REG_AW-1:0] iss2_dst,
   output logic              stall,
   output logic              pair_dep
);
   logic [NUM_REGS-1:0][DATA_W-1:0]  regs;
   logic [NUM_SRC-1:0][REG_AW-1:0]   src_addr;
   logic [NUM_SRC-1:0][DATA_W-1:0]   rd_data;
   wb_t                              wb1, wb2;

   assign wb1 = '{en: wb1_en, addr: wb1_addr, data: wb1_data};
   assign wb2 = '{en: wb2_en, addr: wb2_addr, data: wb2_data};

   assign src_addr[SRC_I1_RD] = i1_Rd;
   assign src_addr[SRC_I1_RM] = i1_Rm;
   assign src_addr[SRC_I2_RD] = i2_Rd;
   assign src_addr[SRC_I2_RM] = i2_Rm;
   assign src_addr[SRC_I2_RN] = i2_Rn;

   // wb2 is the younger instruction, so its data shadows wb1's on both paths.
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (addr_hit(wb2.en, wb2.addr, src_addr[i]))      rd_data[i] = wb2.data;
         else if (addr_hit(wb1.en, wb1.addr, src_addr[i])) rd_data[i] = wb1.data;
         else                                              rd_data[i] = regs[src_addr[i]];
      end
   end

   assign i1_regRd = rd_data[SRC_I1_RD];
   assign i1_regRm = rd_data[SRC_I1_RM];
   assign i2_regRd = rd_data[SRC_I2_RD];
   assign i2_regRm = rd_data[SRC_I2_RM];
   assign i2_regRn = rd_data[SRC_I2_RN];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         regs <= '0;
      end else begin
         if (wb1.en) regs[wb1.addr] <= wb1.data;
         if (wb2.en) regs[wb2.addr] <= wb2.data;
      end
   end

   rf_scoreboard #(.NUM_REGS(NUM_REGS)) u_sb (
      .clk      (clk),
      .reset    (reset),
      .src_addr (src_addr),
      .src_en   (src_en),
      .wb1_en   (wb1.en),
      .wb1_addr (wb1.addr),
      .wb2_en   (wb2.en),
      .wb2_addr (wb2.addr),
      .iss1_en  (iss1_en),
      .iss1_dst (iss1_dst),
      .iss2_en  (iss2_en),
      .iss2_dst (iss2_dst),
      .stall    (stall),
      .pair_dep (pair_dep)
   );
endmodule
